// File: rtl/hazard_unit_pkg.sv
// Shared types for the RV32IF hazard controller: multi-cycle FSM states,
// register-file kinds and the register address width.
package hazard_unit_pkg;

    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } mc_state_e;

    typedef enum logic {
        RF_INT = 1'b0,
        RF_FP  = 1'b1
    } rf_kind_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for one register file: one bit per register,
// set on multi-cycle dispatch and cleared when that result retires or aborts.
module hazard_scoreboard
    import hazard_unit_pkg::*;
#(
    parameter rf_kind_e KIND     = RF_INT,
    parameter int       NUM_REGS = 32,
    parameter int       AW       = ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_i,
    input  logic [AW-1:0]       set_addr_i,
    input  logic                clr_i,
    input  logic [AW-1:0]       clr_addr_i,
    input  logic [AW-1:0]       rd_a_addr_i,
    input  logic [AW-1:0]       rd_b_addr_i,
    output logic                rd_a_o,
    output logic                rd_b_o,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic                set_ok;

    // Integer x0 is hardwired to zero, so a write to it can never be pending.
    assign set_ok = set_i && !(KIND == RF_INT && set_addr_i == '0);

    // NOTE: this is a flop vector rather than a RAM, so it can and does reset
    // as a whole; a real register-file array would not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            if (clr_i)  pend_q[clr_addr_i] <= 1'b0;
            if (set_ok) pend_q[set_addr_i] <= 1'b1;
        end
    end

    assign rd_a_o    = pend_q[rd_a_addr_i];
    assign rd_b_o    = pend_q[rd_b_addr_i];
    assign pending_o = pend_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage RV32IF pipeline: load-use, multi-cycle
// scoreboard RAW/WAW, multi-cycle structural and write-back port hazards.
module hazard_unit #(
    parameter int ADDR_W     = hazard_unit_pkg::ADDR_W,
    parameter int NUM_REGS   = 32,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] id_rs1_addr_i,
    input  logic [ADDR_W-1:0] id_rs2_addr_i,
    input  logic              id_rs_F_i,
    input  logic [ADDR_W-1:0] id_rd_addr_i,
    input  logic              id_rd_wren_I_i,
    input  logic              id_rd_wren_F_i,
    input  logic              id_is_mc_i,
    input  logic [ADDR_W-1:0] ex_rd_addr_i,
    input  logic              ex_mem_rden_i,
    input  logic              ex_rd_wren_I_i,
    input  logic              ex_rd_wren_F_i,
    input  logic              ex_br_taken_i,
    input  logic              mc_done_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              stall_ex_o,
    output logic              flush_id_o,
    output logic              flush_ex_o,
    output logic              mc_wb_sel_o,
    output logic              mc_busy_o,
    output logic              mc_timeout_o
);

    import hazard_unit_pkg::*;

    mc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mc_rd_q;
    rf_kind_e          mc_kind_q;
    logic              timeout_q;

    logic                int_rs1_p, int_rs2_p, fp_rs1_p, fp_rs2_p;
    logic [NUM_REGS-1:0] int_pend, fp_pend;

    logic load_use, raw_sb, waw_sb, mc_struct, wb_conflict;
    logic stall, flush, dispatch, timeout_hit, mc_clear;

    assign load_use = ex_mem_rden_i
                   && (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i)
                   && ((ex_rd_wren_F_i && id_rs_F_i)
                    || (ex_rd_wren_I_i && !id_rs_F_i && ex_rd_addr_i != '0));
    assign raw_sb      = id_rs_F_i ? (fp_rs1_p || fp_rs2_p) : (int_rs1_p || int_rs2_p);
    assign waw_sb      = (id_rd_wren_F_i && fp_pend[id_rd_addr_i])
                      || (id_rd_wren_I_i && int_pend[id_rd_addr_i]);
    assign mc_struct   = id_is_mc_i && state_q != IDLE;
    assign wb_conflict = state_q == WB;

    // A taken branch flushes ID, so its hazards no longer matter; a WB freeze
    // keeps the branch in EX and its flush is taken one cycle later.
    assign stall = !rst_i && (wb_conflict
                || (!ex_br_taken_i && (load_use || raw_sb || waw_sb || mc_struct)));
    assign flush = !rst_i && ex_br_taken_i && !wb_conflict;

    assign dispatch    = state_q == IDLE && id_is_mc_i && !stall && !flush;
    assign timeout_hit = state_q == BUSY && !mc_done_i
                      && cnt_q == CNT_W'(MC_TIMEOUT - 1);
    assign mc_clear    = wb_conflict || timeout_hit;

    // NOTE: every path assigns state_d after its default, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dispatch) state_d = BUSY;
            BUSY:    if (mc_done_i) state_d = WB;
                     else if (timeout_hit) state_d = IDLE;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mc_rd_q   <= '0;
            mc_kind_q <= RF_INT;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (dispatch) begin
                cnt_q     <= '0;
                mc_rd_q   <= id_rd_addr_i;
                mc_kind_q <= id_rd_wren_F_i ? RF_FP : RF_INT;
            end else if (state_q == BUSY && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end

    hazard_scoreboard #(.KIND(RF_INT), .NUM_REGS(NUM_REGS), .AW(ADDR_W)) u_sb_int (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_i       (dispatch && id_rd_wren_I_i && !id_rd_wren_F_i),
        .set_addr_i  (id_rd_addr_i),
        .clr_i       (mc_clear && mc_kind_q == RF_INT),
        .clr_addr_i  (mc_rd_q),
        .rd_a_addr_i (id_rs1_addr_i),
        .rd_b_addr_i (id_rs2_addr_i),
        .rd_a_o      (int_rs1_p),
        .rd_b_o      (int_rs2_p),
        .pending_o   (int_pend)
    );

    hazard_scoreboard #(.KIND(RF_FP), .NUM_REGS(NUM_REGS), .AW(ADDR_W)) u_sb_fp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_i       (dispatch && id_rd_wren_F_i),
        .set_addr_i  (id_rd_addr_i),
        .clr_i       (mc_clear && mc_kind_q == RF_FP),
        .clr_addr_i  (mc_rd_q),
        .rd_a_addr_i (id_rs1_addr_i),
        .rd_b_addr_i (id_rs2_addr_i),
        .rd_a_o      (fp_rs1_p),
        .rd_b_o      (fp_rs2_p),
        .pending_o   (fp_pend)
    );

    assign stall_if_o   = stall;
    assign stall_id_o   = stall;
    assign stall_ex_o   = wb_conflict;
    assign mc_wb_sel_o  = wb_conflict;
    assign flush_id_o   = flush;
    assign flush_ex_o   = flush;
    assign mc_busy_o    = state_q != IDLE;
    assign mc_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected output vectors are queued as each
// step is driven and popped against the DUT mid-cycle.
module tb_hazard_unit;

    logic       clk, rst;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd;
    logic       id_rs_f, id_wren_i, id_wren_f, id_is_mc;
    logic       ex_rden, ex_wren_i, ex_wren_f, ex_br, mc_done;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic       mc_wb_sel, mc_busy, mc_timeout;

    // Output vector: {stall_if, stall_id, stall_ex, flush_id, flush_ex, wb_sel, busy, timeout}
    localparam logic [7:0] E_0  = 8'b0000_0000;
    localparam logic [7:0] E_S  = 8'b1100_0000;
    localparam logic [7:0] E_WB = 8'b0010_0100;
    localparam logic [7:0] E_F  = 8'b0001_1000;
    localparam logic [7:0] E_B  = 8'b0000_0010;
    localparam logic [7:0] E_T  = 8'b0000_0001;

    typedef struct {
        string      tag;
        logic [7:0] e;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    hazard_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs1_addr_i  (id_rs1),
        .id_rs2_addr_i  (id_rs2),
        .id_rs_F_i      (id_rs_f),
        .id_rd_addr_i   (id_rd),
        .id_rd_wren_I_i (id_wren_i),
        .id_rd_wren_F_i (id_wren_f),
        .id_is_mc_i     (id_is_mc),
        .ex_rd_addr_i   (ex_rd),
        .ex_mem_rden_i  (ex_rden),
        .ex_rd_wren_I_i (ex_wren_i),
        .ex_rd_wren_F_i (ex_wren_f),
        .ex_br_taken_i  (ex_br),
        .mc_done_i      (mc_done),
        .stall_if_o     (stall_if),
        .stall_id_o     (stall_id),
        .stall_ex_o     (stall_ex),
        .flush_id_o     (flush_id),
        .flush_ex_o     (flush_ex),
        .mc_wb_sel_o    (mc_wb_sel),
        .mc_busy_o      (mc_busy),
        .mc_timeout_o   (mc_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; ex_rd = 5'd0;
        id_rs_f = 1'b0; id_wren_i = 1'b0; id_wren_f = 1'b0; id_is_mc = 1'b0;
        ex_rden = 1'b0; ex_wren_i = 1'b0; ex_wren_f = 1'b0; ex_br = 1'b0;
        mc_done = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.e   = e;
        q.push_back(x);
    endtask

    task automatic check_pop();
        exp_t       x;
        logic [7:0] obs;
        x   = q.pop_front();
        obs = {stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_wb_sel, mc_busy, mc_timeout};
        tests++;
        assert (obs === x.e) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", x.tag, obs, x.e);
        end
    endtask

    // One pipeline cycle: inputs already driven just after negedge.
    task automatic cyc(input string tag, input logic [7:0] e);
        push_exp(tag, e);
        #2;
        check_pop();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        #1;
        push_exp("reset", E_0);
        check_pop();
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Load-use: EX LW x5, ID ADD x6,x5,x1
        ex_rden = 1; ex_rd = 5; ex_wren_i = 1;
        id_rs1 = 5; id_rs2 = 1; id_rd = 6; id_wren_i = 1;
        cyc("load_use", E_S);
        ex_rden = 0; ex_rd = 0; ex_wren_i = 0;
        cyc("load_use_release", E_0);

        // x0 never hazards; f0 does; file kinds must match
        clr_in(); ex_rden = 1; ex_rd = 0; ex_wren_i = 1; id_wren_i = 1; id_rd = 6;
        cyc("lw_x0", E_0);
        clr_in(); ex_rden = 1; ex_rd = 0; ex_wren_f = 1; id_rs_f = 1; id_wren_f = 1; id_rd = 4;
        cyc("flw_f0", E_S);
        clr_in(); ex_rden = 1; ex_rd = 5; ex_wren_f = 1; id_rs1 = 5; id_wren_i = 1; id_rd = 6;
        cyc("flw_vs_int", E_0);

        // FDIV f3 then FADD f4,f3,f1; done in the 10th BUSY cycle
        clr_in(); id_is_mc = 1; id_rd = 3; id_wren_f = 1; id_rs_f = 1; id_rs1 = 1; id_rs2 = 2;
        cyc("fdiv_dispatch", E_0);
        clr_in(); id_rd = 4; id_wren_f = 1; id_rs_f = 1; id_rs1 = 3; id_rs2 = 1;
        for (int i = 0; i < 9; i++) cyc("fp_raw_busy", E_S | E_B);
        mc_done = 1;
        cyc("fp_raw_done", E_S | E_B);
        mc_done = 0;
        cyc("fp_raw_wb", E_S | E_WB | E_B);
        cyc("fp_raw_release", E_0);
        clr_in(); mc_done = 1;
        cyc("done_in_idle", E_0);
        mc_done = 0;
        cyc("done_in_idle_after", E_0);

        // DIV x7, then structural / WAW / RAW / unrelated ID instructions
        clr_in(); id_is_mc = 1; id_rd = 7; id_wren_i = 1; id_rs1 = 1; id_rs2 = 2;
        cyc("div_x7_dispatch", E_0);
        id_rd = 9;
        cyc("mc_struct", E_S | E_B);
        id_is_mc = 0; id_rd = 7;
        cyc("waw_x7", E_S | E_B);
        id_rd = 8;
        cyc("add_x8", E_B);
        id_rd = 10; id_rs1 = 7;
        cyc("raw_x7", E_S | E_B);
        clr_in(); id_rs_f = 1; id_rs1 = 7; id_rd = 4; id_wren_f = 1;
        cyc("f7_not_x7", E_B);
        clr_in(); id_rd = 8; id_wren_i = 1; mc_done = 1;
        cyc("div_done", E_B);
        clr_in(); id_is_mc = 1; id_rd = 9; id_wren_i = 1; id_rs1 = 1; id_rs2 = 2;
        cyc("mc_struct_wb", E_S | E_WB | E_B);
        cyc("div_x9_dispatch", E_0);

        // Branch resolved while WB freezes EX
        clr_in(); mc_done = 1;
        cyc("div_x9_done", E_B);
        mc_done = 0; ex_br = 1;
        cyc("branch_in_wb", E_S | E_WB | E_B);
        cyc("branch_after_wb", E_F);

        // Branch overrides load-use and suppresses dispatch
        clr_in(); ex_br = 1; ex_rden = 1; ex_rd = 5; ex_wren_i = 1; id_rs1 = 5; id_wren_i = 1;
        cyc("branch_over_load_use", E_F);
        clr_in(); ex_br = 1; id_is_mc = 1; id_rd = 13; id_wren_i = 1;
        cyc("branch_blocks_dispatch", E_F);
        clr_in(); id_rs1 = 13; id_rd = 14; id_wren_i = 1;
        cyc("no_dispatch_after_branch", E_0);

        // Timeout: DIV x12 never completes
        clr_in(); id_is_mc = 1; id_rd = 12; id_wren_i = 1; id_rs1 = 1; id_rs2 = 2;
        cyc("div_x12_dispatch", E_0);
        clr_in(); id_rs1 = 12; id_rd = 14; id_wren_i = 1;
        for (int i = 0; i < 64; i++) cyc("timeout_busy", E_S | E_B);
        cyc("timeout_abort", E_T);
        mc_done = 1;
        cyc("timeout_sticky", E_T);
        mc_done = 0;

        // FP f0 is tracked; reset mid-BUSY clears everything asynchronously
        clr_in(); id_is_mc = 1; id_rd = 0; id_wren_f = 1;
        cyc("fdiv_f0_dispatch", E_T);
        clr_in(); id_rs_f = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 5; id_wren_f = 1;
        cyc("raw_f0", E_S | E_B | E_T);
        rst = 1'b1;
        push_exp("reset_async", E_0);
        #1;
        check_pop();
        @(negedge clk);
        #1;
        rst = 1'b0;
        cyc("post_reset_f0", E_0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
